// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared constants and state encoding for the shared-adder scheduler
//   DATA_W        operand/result width
//   SEL_*         adder architecture selectors for ADDER_SEL
//   st_t          output-register occupancy state
package adder_share_pkg;
    localparam int DATA_W   = 32;
    localparam int SEL_CRA  = 0;
    localparam int SEL_CLA  = 1;
    localparam int SEL_CSA  = 2;
    localparam int SEL_CSKA = 3;
    localparam int SEL_KSA  = 4;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} st_t;
endpackage

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: W-bit adder built from 4-bit two-level lookahead groups
//   a, b in W   operands (W a multiple of 4)
//   sum  out W  a+b mod 2^W
module carry_lookahead_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    logic [W-1:0] g, p;
    logic [4:0]   cv;
    logic         cin, t;
    assign g = a & b;
    assign p = a ^ b;
    // Each group carry is a flat sum of generate/propagate products, not a chain.
    always_comb begin
        cin = 1'b0;
        cv  = '0;
        t   = 1'b0;
        sum = '0;
        for (int base = 0; base < W; base += 4) begin
            for (int k = 0; k <= 4; k++) begin
                t = cin;
                for (int m = 0; m < k; m++) t = t & p[base+m];
                cv[k] = t;
                for (int j = 1; j <= k; j++) begin
                    t = g[base+j-1];
                    for (int m = j; m < k; m++) t = t & p[base+m];
                    cv[k] = cv[k] | t;
                end
            end
            sum[base+:4] = p[base+:4] ^ cv[3:0];
            cin          = cv[4];
        end
    end
endmodule

// File: rtl/carry_ripple_adder.sv
// carry_ripple_adder: W-bit ripple-carry adder, carry-out dropped
//   a, b in W   operands
//   sum  out W  a+b mod 2^W
module carry_ripple_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    logic c;
    always_comb begin
        c   = 1'b0;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
    end
endmodule

// File: rtl/carry_select_adder.sv
// carry_select_adder: W-bit adder of 8-bit blocks precomputed for both carry-ins
//   a, b in W   operands (W a multiple of 8)
//   sum  out W  a+b mod 2^W
module carry_select_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    logic       c;
    logic [8:0] s0, s1;
    always_comb begin
        c   = 1'b0;
        s0  = '0;
        s1  = '0;
        sum = '0;
        for (int base = 0; base < W; base += 8) begin
            s0           = {1'b0, a[base+:8]} + {1'b0, b[base+:8]};
            s1           = {1'b0, a[base+:8]} + {1'b0, b[base+:8]} + 9'd1;
            sum[base+:8] = c ? s1[7:0] : s0[7:0];
            c            = c ? s1[8] : s0[8];
        end
    end
endmodule

// File: rtl/carry_skip_adder.sv
// carry_skip_adder: W-bit adder of 4-bit ripple blocks with carry bypass on full propagate
//   a, b in W   operands (W a multiple of 4)
//   sum  out W  a+b mod 2^W
module carry_skip_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    logic c, rc;
    always_comb begin
        c   = 1'b0;
        rc  = 1'b0;
        sum = '0;
        for (int base = 0; base < W; base += 4) begin
            rc = c;
            for (int k = base; k < base + 4; k++) begin
                sum[k] = a[k] ^ b[k] ^ rc;
                rc     = (a[k] & b[k]) | (rc & (a[k] ^ b[k]));
            end
            c = (&(a[base+:4] ^ b[base+:4])) ? c : rc;
        end
    end
endmodule

// File: rtl/kogge_stone_adder.sv
// kogge_stone_adder: W-bit parallel-prefix adder, log2(W) prefix stages
//   a, b in W   operands
//   sum  out W  a+b mod 2^W
module kogge_stone_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    logic [W-1:0] g, p, ng, np;
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        ng = '0;
        np = '0;
        for (int d = 1; d < W; d = d * 2) begin
            ng = g;
            np = p;
            for (int i = d; i < W; i++) begin
                ng[i] = g[i] | (p[i] & g[i-d]);
                np[i] = p[i] & p[i-d];
            end
            g = ng;
            p = np;
        end
        sum = (a ^ b) ^ {g[W-2:0], 1'b0};
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, first request at or after pointer wins
//   req     in  N         request vector
//   enable  in  1         grants allowed this cycle
//   pointer in  log2(N)   highest-priority index
//   grant   out N         one-hot grant or zero
//   index   out log2(N)   index of the granted request (0 when none)
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);
    int k;
    // Scan from the farthest offset back to the pointer so the nearest request wins last.
    always_comb begin
        grant = '0;
        index = '0;
        k     = 0;
        for (int off = N - 1; off >= 0; off--) begin
            k = int'(pointer) + off;
            if (k >= N) k = k - N;
            if (enable && req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                index    = IW'(k);
            end
        end
    end
endmodule

// File: rtl/adder_share_sched.sv
// adder_share_sched: round-robin scheduler sharing one 32-bit adder among NUM_REQ requesters
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready per-requester handshake (ready one-hot or zero, same cycle)
//   i_req_a, i_req_b        packed operands, requester k at [32k+31:32k]
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_sum, o_rsp_id     registered sum and owning requester
//   o_op_cnt                saturating count of completed responses
//   o_chk_err               only with ADDER_SHARE_SCHED_CHECK_EN: sticky adder self-check error
module adder_share_sched
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDER_SEL = 4,
    parameter int CNT_W     = 16,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_W-1:0]         o_rsp_sum,
    output logic [IDW-1:0]            o_rsp_id,
    output logic [CNT_W-1:0]          o_op_cnt
`ifdef ADDER_SHARE_SCHED_CHECK_EN
    ,
    output logic                      o_chk_err
`endif
);
    st_t               state;
    logic [IDW-1:0]    ptr, gidx;
    logic [DATA_W-1:0] a_sel, b_sel, add_sum;
    logic              accept, xfer, drain;

    assign o_rsp_valid = (state == ST_FULL);
    assign drain       = o_rsp_valid & i_rsp_ready;
    assign accept      = (state == ST_EMPTY) | drain;
    assign xfer        = |o_req_ready;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (i_req_valid),
        .enable  (accept & ~i_rst),
        .pointer (ptr),
        .grant   (o_req_ready),
        .index   (gidx)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_req_ready[k]) begin
                a_sel = i_req_a[k*DATA_W+:DATA_W];
                b_sel = i_req_b[k*DATA_W+:DATA_W];
            end
        end
    end

    if (ADDER_SEL == SEL_CRA) begin : g_cra
        carry_ripple_adder #(.W(DATA_W)) u_add (.a(a_sel), .b(b_sel), .sum(add_sum));
    end else if (ADDER_SEL == SEL_CLA) begin : g_cla
        carry_lookahead_adder #(.W(DATA_W)) u_add (.a(a_sel), .b(b_sel), .sum(add_sum));
    end else if (ADDER_SEL == SEL_CSA) begin : g_csa
        carry_select_adder #(.W(DATA_W)) u_add (.a(a_sel), .b(b_sel), .sum(add_sum));
    end else if (ADDER_SEL == SEL_CSKA) begin : g_cska
        carry_skip_adder #(.W(DATA_W)) u_add (.a(a_sel), .b(b_sel), .sum(add_sum));
    end else if (ADDER_SEL == SEL_KSA) begin : g_ksa
        kogge_stone_adder #(.W(DATA_W)) u_add (.a(a_sel), .b(b_sel), .sum(add_sum));
    end else begin : g_bad
        $error("adder_share_sched: ADDER_SEL out of range");
    end

    // A grant in the same cycle as a drain reloads the register, so FULL persists without a bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_EMPTY;
            ptr       <= '0;
            o_rsp_sum <= '0;
            o_rsp_id  <= '0;
            o_op_cnt  <= '0;
        end else begin
            if (drain && !(&o_op_cnt)) o_op_cnt <= o_op_cnt + 1'b1;
            if (xfer) begin
                state     <= ST_FULL;
                o_rsp_sum <= add_sum;
                o_rsp_id  <= gidx;
                ptr       <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            end else if (drain) begin
                state <= ST_EMPTY;
            end
        end
    end

`ifdef ADDER_SHARE_SCHED_CHECK_EN
    logic [DATA_W-1:0] ref_sum;
    logic              err_q, mis;
    assign mis       = o_rsp_valid & (o_rsp_sum != ref_sum);
    assign o_chk_err = err_q | mis;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ref_sum <= '0;
            err_q   <= 1'b0;
        end else begin
            if (xfer) ref_sum <= a_sel + b_sel;
            if (mis) err_q <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_adder_share_sched.sv
// tb_adder_share_sched: directed plus random check of all five adder builds against a transaction model
module tb_adder_share_sched;
    localparam int NR = 4;
    localparam int ND = 5;
    localparam int CMAX = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*32-1:0] req_a, req_b;
    logic             rsp_ready;

    logic [NR-1:0] rdy [ND];
    logic          vld [ND];
    logic [31:0]   sm  [ND];
    logic [1:0]    id  [ND];
    logic [3:0]    cnt [ND];
`ifdef ADDER_SHARE_SCHED_CHECK_EN
    logic          err [ND];
`endif

    always #5 clk = ~clk;

    genvar s;
    for (s = 0; s < ND; s++) begin : g_dut
        adder_share_sched #(.NUM_REQ(NR), .ADDER_SEL(s), .CNT_W(4)) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_req_valid (req_valid),
            .o_req_ready (rdy[s]),
            .i_req_a     (req_a),
            .i_req_b     (req_b),
            .o_rsp_valid (vld[s]),
            .i_rsp_ready (rsp_ready),
            .o_rsp_sum   (sm[s]),
            .o_rsp_id    (id[s]),
            .o_op_cnt    (cnt[s])
`ifdef ADDER_SHARE_SCHED_CHECK_EN
            ,
            .o_chk_err   (err[s])
`endif
        );
    end

    int total = 0;
    int bad = 0;

    // Transaction-level model: one result slot, a rotating priority pointer and a saturating count.
    bit          m_full;
    logic [31:0] m_sum;
    int          m_id, m_ptr, m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input bit v, input logic [31:0] a, input logic [31:0] b);
        req_valid[k]    = v;
        req_a[k*32+:32] = a;
        req_b[k*32+:32] = b;
    endtask

    task automatic step();
        int          g;
        int          k;
        logic [3:0]  er;
        #1;
        g = -1;
        if (!rst && (!m_full || rsp_ready))
            for (int off = 0; off < NR; off++) begin
                k = (m_ptr + off) % NR;
                if (g < 0 && req_valid[k]) g = k;
            end
        er = (g < 0) ? 4'b0000 : 4'(1 << g);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("ready[%0d]", d), 64'(rdy[d]), 64'(er));
            chk($sformatf("valid[%0d]", d), 64'(vld[d]), 64'(m_full));
            chk($sformatf("sum[%0d]", d), 64'(sm[d]), 64'(m_sum));
            chk($sformatf("id[%0d]", d), 64'(id[d]), 64'(m_id));
            chk($sformatf("cnt[%0d]", d), 64'(cnt[d]), 64'(m_cnt));
`ifdef ADDER_SHARE_SCHED_CHECK_EN
            chk($sformatf("chk_err[%0d]", d), 64'(err[d]), 64'd0);
`endif
        end
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_sum = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_full && rsp_ready && m_cnt < CMAX) m_cnt++;
            if (g >= 0) begin
                m_sum  = req_a[g*32+:32] + req_b[g*32+:32];
                m_id   = g;
                m_full = 1;
                m_ptr  = (g + 1) % NR;
            end else if (m_full && rsp_ready) begin
                m_full = 0;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000 | $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_full = 0; m_sum = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
        req_valid = 4'b1111;
        step(); step();
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        step();
        set_req(1, 1, 32'h5, 32'h7); step();
        set_req(1, 0, 0, 0); step(); step();
        set_req(0, 1, 32'hFFFF_FFFF, 32'h2); step();
        set_req(0, 1, 32'h8000_0000, 32'h8000_0000); step();
        req_valid = '0; step();
        for (int k = 0; k < NR; k++) set_req(k, 1, $urandom, $urandom);
        repeat (6) step();
        req_valid = '0; step();
        set_req(1, 1, $urandom, $urandom); step();
        for (int k = 0; k < NR; k++) set_req(k, 1, $urandom, $urandom);
        repeat (4) step();
        req_valid = '0;
        set_req(0, 1, 32'h1234_5678, 32'h1111_1111); step();
        req_valid = '0; rsp_ready = 1'b0;
        set_req(2, 1, 32'hDEAD_BEEF, 32'h0000_0001);
        repeat (3) step();
        rsp_ready = 1'b1; step();
        req_valid = '0; step();
        set_req(3, 1, 32'h0F0F_0F0F, 32'hF0F0_F0F1); rsp_ready = 1'b0; step();
        req_valid = '0; step();
        rst = 1'b1; rsp_ready = 1'b1; step();
        rst = 1'b0; step();
        repeat (400) begin
            rst = ($urandom_range(0, 99) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NR; k++) set_req(k, $urandom_range(0, 1), rnd_op(), rnd_op());
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
